fifo_get_stage: RTL and testbench

FIFO_GET_STAGE -- requirements
Module: fifo_get_stage

---
 rtl/fifo_get_stage_pkg.sv | 19 +
 rtl/fifo_get_stage_skid_buffer.sv | 63 ++++++
 rtl/fifo_get_stage.sv | 65 ++++++
 tb/tb_fifo_get_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_get_stage_pkg.sv
// Shared constants and helpers for the FIFO get stage.
`timescale 1ns/1ps
package fifo_get_stage_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WORD_COUNT_W   = 16;
  localparam int SKID_DEPTH     = 2;

  typedef logic [1:0] occ_t;

  // True when a word requested now will still have a buffer slot when it lands.
  function automatic logic room_for_read(input occ_t count, input logic inflight,
                                         input logic pop);
    logic [2:0] committed;
    committed = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_get_stage_skid_buffer.sv
// Two-entry in-order buffer: head entry is presented, tail holds the next word.
`timescale 1ns/1ps
module get_skid_buffer
  import fifo_get_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output occ_t                  count_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 tail_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever remains.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_get_stage.sv
// Pulls words from a 1-cycle-latency FIFO and presents them to a core with valid/enable.
// Optional FIFO_GET_COUNT_EN adds the WORD_COUNT delivered-word counter.
`timescale 1ns/1ps
module fifo_get_stage
  import fifo_get_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EMPTY,
  output logic                    FIFO_READ_EN,
  input  logic [DATA_WIDTH-1:0]   FIFO_DATA,
  input  logic                    ENABLE,
  output logic [DATA_WIDTH-1:0]   DATA_OUT,
  output logic                    DATA_VALID
`ifdef FIFO_GET_COUNT_EN
  ,
  output logic [WORD_COUNT_W-1:0] WORD_COUNT
`endif
);

  logic inflight_q, inflight_d;
  logic pop;
  occ_t count;

  assign DATA_VALID = (count != 2'd0);
  assign pop        = DATA_VALID & ENABLE;

  // Reads are gated by RESET so nothing is requested while reset is held.
  assign FIFO_READ_EN = RESET & ~EMPTY & room_for_read(count, inflight_q, pop);
  assign inflight_d   = FIFO_READ_EN;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  get_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (FIFO_DATA),
    .head_o  (DATA_OUT),
    .count_o (count)
  );

`ifdef FIFO_GET_COUNT_EN
  logic [WORD_COUNT_W-1:0] word_count_q, word_count_d;

  assign word_count_d = pop ? word_count_q + 1'b1 : word_count_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) word_count_q <= '0;
    else        word_count_q <= word_count_d;
  end

  assign WORD_COUNT = word_count_q;
`else
`endif

endmodule

// File: tb/tb_fifo_get_stage.sv
// Directed bench for fifo_get_stage with a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_get_stage;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          EMPTY = 1'b1;
  logic          ENABLE = 1'b0;
  logic [DW-1:0] FIFO_DATA = 16'hDEAD;
  logic          FIFO_READ_EN;
  logic [DW-1:0] DATA_OUT;
  logic          DATA_VALID;
`ifdef FIFO_GET_COUNT_EN
  logic [15:0]   WORD_COUNT;
`endif

  always #5 CLK = ~CLK;

  fifo_get_stage #(.DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EMPTY        (EMPTY),
    .FIFO_READ_EN (FIFO_READ_EN),
    .FIFO_DATA    (FIFO_DATA),
    .ENABLE       (ENABLE),
    .DATA_OUT     (DATA_OUT),
    .DATA_VALID   (DATA_VALID)
`ifdef FIFO_GET_COUNT_EN
    ,
    .WORD_COUNT   (WORD_COUNT)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: words held downstream of the FIFO, plus one word requested last cycle.
  logic [DW-1:0] mq[$];
  logic          infl_m = 1'b0;
  logic [15:0]   wc_m = '0;
  logic [DW-1:0] src_next = '0;
  logic [DW-1:0] pops[$];
  int            pop_cyc[$];
  int            rd_cnt = 0;
  int            cyc = 0;
  int            first_rd_cyc = -1;
  int            first_vld_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic emp, input logic en);
    logic exp_rd, pop_m, dut_rd;
    @(negedge CLK);
    EMPTY  = emp;
    ENABLE = en;
    #1;
    pop_m  = en && (mq.size() != 0);
    exp_rd = RESET && !emp && ((mq.size() + int'(infl_m) - int'(pop_m)) < 2);
    chk("read_en", {31'b0, FIFO_READ_EN}, {31'b0, exp_rd});
    chk("data_valid", {31'b0, DATA_VALID}, {31'b0, (mq.size() != 0)});
    if (mq.size() != 0) chk("data_out", {16'b0, DATA_OUT}, {16'b0, mq[0]});
`ifdef FIFO_GET_COUNT_EN
    chk("word_count", {16'b0, WORD_COUNT}, {16'b0, wc_m});
`endif
    dut_rd = FIFO_READ_EN;
    if (dut_rd) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (mq.size() != 0 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (pop_m) begin
      pops.push_back(mq[0]);
      pop_cyc.push_back(cyc);
    end
    @(posedge CLK);
    if (pop_m) begin
      void'(mq.pop_front());
      wc_m = wc_m + 16'd1;
    end
    if (infl_m) mq.push_back(FIFO_DATA);
    infl_m = exp_rd;
    cyc++;
    #1;
    if (dut_rd) begin
      FIFO_DATA = src_next;
      src_next  = src_next + 1'b1;
    end else begin
      FIFO_DATA = 16'hDEAD;
    end
  endtask

  // Asserts reset between clock edges, checks the immediate clear, then releases.
  task automatic do_reset();
    #2;
    RESET = 1'b0;
    EMPTY = 1'b1;
    #1;
    chk("rst_valid", {31'b0, DATA_VALID}, 32'h0);
    chk("rst_read_en", {31'b0, FIFO_READ_EN}, 32'h0);
    chk("rst_data_out", {16'b0, DATA_OUT}, 32'h0);
`ifdef FIFO_GET_COUNT_EN
    chk("rst_word_count", {16'b0, WORD_COUNT}, 32'h0);
`endif
    mq.delete();
    infl_m = 1'b0;
    wc_m   = '0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    FIFO_DATA = 16'hDEAD;
    pops.delete();
    pop_cyc.delete();
    rd_cnt = 0;
    cyc = 0;
    first_rd_cyc = -1;
    first_vld_cyc = -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;

    // Streaming 0x0001..0x0008 with the core always ready
    do_reset();
    src_next = 16'h0001;
    for (int i = 0; i < 12; i++) step(src_next > 16'h0008, 1'b1);
    chk("start_latency", first_vld_cyc - first_rd_cyc, 32'd2);
    chk("stream_count", pops.size(), 32'd8);
    for (int i = 0; i < 8 && i < pops.size(); i++)
      chk("stream_word", {16'b0, pops[i]}, i + 1);
    if (pop_cyc.size() == 8) chk("stream_no_bubble", pop_cyc[7] - pop_cyc[0], 32'd7);

    // Core stalled for 5 cycles: exactly two reads, head holds
    do_reset();
    src_next = 16'h0001;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("stall_reads", rd_cnt, 32'd2);
    chk("stall_head", {16'b0, DATA_OUT}, 32'h0001);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3 && i < pops.size(); i++)
      chk("stall_resume_word", {16'b0, pops[i]}, i + 1);

    // Upstream empty throughout
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, i[0]);
    chk("empty_reads", rd_cnt, 32'd0);
    chk("empty_valid", {31'b0, DATA_VALID}, 32'h0);

    // EMPTY toggling every cycle, ENABLE from a fixed irregular pattern
    do_reset();
    src_next = 16'h0040;
    pat = 32'hB3C5_96E1;
    for (int i = 0; i < 32; i++) step(i[0], pat[i]);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    chk("toggle_all_delivered", pops.size(), rd_cnt);
    for (int i = 0; i < pops.size(); i++)
      chk("toggle_order", {16'b0, pops[i]}, 32'h0040 + i);

    // Reset while the buffer is full discards both held words
    do_reset();
    src_next = 16'h0101;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("full_before_reset", {31'b0, DATA_VALID}, 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    if (pops.size() > 0) chk("after_reset_word", {16'b0, pops[0]}, 32'h0103);
    else chk("after_reset_word", 32'hFFFF_FFFF, 32'h0103);

`ifdef FIFO_GET_COUNT_EN
    // Word counter wraps after 65536 pops
    do_reset();
    src_next = 16'h0000;
    for (int i = 0; i < 70000 && pops.size() < 65537; i++) step(1'b0, 1'b1);
    @(negedge CLK);
    chk("wrap_pops", pops.size(), 32'd65537);
    chk("wrap_word_count", {16'b0, WORD_COUNT}, 32'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
